instruction_loader: RTL

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/instruction_loader.sv
// instruction_loader
// Receives a program as a big-endian byte stream and writes it, one 28-bit
// instruction at a time, into an instruction memory. The processor is held in
// reset until a complete program has been loaded.
//
// Ports
//   Clock          : single clock, rising edge
//   Reset          : asynchronous active-high reset
//   iStart         : request a new load (only honoured when idle)
//   iLength        : number of instructions to load, clamped to the memory depth
//   iByte          : program byte, first byte of an instruction is its MSB
//   iByteValid     : iByte is valid
//   iAbort         : cancel a load in progress
//   oByteReady     : loader accepts a byte this cycle
//   oWriteEnable   : one-cycle write strobe to instruction memory
//   oWriteAddress  : instruction memory write address
//   oInstruction   : instruction word to write
//   oCpuReset      : processor reset request
//   oBusy          : load in progress
//   oDone          : one-cycle pulse when a load completes
//   oError         : sticky format/abort error, cleared by the next accepted start
module instruction_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iStart,
    input  logic [ADDR_WIDTH:0]   iLength,
    input  logic [7:0]            iByte,
    input  logic                  iByteValid,
    input  logic                  iAbort,
    output logic                  oByteReady,
    output logic                  oWriteEnable,
    output logic [ADDR_WIDTH-1:0] oWriteAddress,
    output logic [27:0]           oInstruction,
    output logic                  oCpuReset,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oError
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0]   MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   LEN_ZERO = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q,   state_d;
    logic [ADDR_WIDTH:0]   len_q,     len_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [1:0]            cnt_q,     cnt_d;
    logic [31:0]           asm_q,     asm_d;
    logic                  loaded_q,  loaded_d;
    logic                  error_q,   error_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [27:0]           instr_q,   instr_d;

    logic [ADDR_WIDTH:0]   len_sel_s;
    logic [31:0]           asm_next_s;
    logic                  last_word_s;

    // Requested length clamped to the memory depth, and the assembly word
    // as it would look after shifting in the current byte.
    always_comb begin
        len_sel_s   = (iLength > MAX_LEN) ? MAX_LEN : iLength;
        asm_next_s  = {asm_q[23:0], iByte};
        // Zero-extend the address so a full-depth load ends at 2^N-1 without wrapping.
        last_word_s = ({1'b0, addr_q} == (len_q - LEN_ONE));
    end

    // Next-state and register update logic of the load FSM.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        loaded_d  = loaded_q;
        error_d   = error_q;
        wr_addr_d = wr_addr_q;
        instr_d   = instr_q;

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    len_d    = len_sel_s;
                    addr_d   = {ADDR_WIDTH{1'b0}};
                    cnt_d    = 2'd0;
                    error_d  = 1'b0;
                    loaded_d = 1'b0;
                    state_d  = (len_sel_s == LEN_ZERO) ? S_DONE : S_RECV;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RECV: begin
                // Abort wins over a byte arriving in the same cycle.
                if (iAbort) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else if (iByteValid) begin
                    asm_d = asm_next_s;
                    if (cnt_q == 2'd3) begin
                        cnt_d     = 2'd0;
                        state_d   = S_WRITE;
                        // Present the write on the next cycle straight from flops.
                        wr_addr_d = addr_q;
                        instr_d   = asm_next_s[27:0];
                        if (asm_next_s[31:28] != 4'd0) begin
                            error_d = 1'b1;
                        end else begin
                            error_d = error_q;
                        end
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
                    state_d = S_RECV;
                end
            end

            S_WRITE: begin
                if (iAbort) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else if (last_word_s) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    cnt_d   = 2'd0;
                    state_d = S_RECV;
                end
            end

            S_DONE: begin
                loaded_d = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, asynchronously cleared by Reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            len_q     <= LEN_ZERO;
            addr_q    <= {ADDR_WIDTH{1'b0}};
            cnt_q     <= 2'd0;
            asm_q     <= 32'd0;
            loaded_q  <= 1'b0;
            error_q   <= 1'b0;
            wr_addr_q <= {ADDR_WIDTH{1'b0}};
            instr_q   <= 28'd0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            loaded_q  <= loaded_d;
            error_q   <= error_d;
            wr_addr_q <= wr_addr_d;
            instr_q   <= instr_d;
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        oByteReady    = (state_q == S_RECV);
        oWriteEnable  = (state_q == S_WRITE);
        oBusy         = (state_q == S_RECV) || (state_q == S_WRITE);
        oDone         = (state_q == S_DONE);
        oCpuReset     = !loaded_q || (state_q == S_RECV) || (state_q == S_WRITE);
        oError        = error_q;
        oWriteAddress = wr_addr_q;
        oInstruction  = instr_q;
    end

endmodule
